lsu: RTL and testbench

Load/store unit sitting directly behind the execute stage: it consumes the load/store classification, effective address and store data produced by the ALU and performs the corresponding data-memory transaction over a req/gnt/rvalid handshake. It handles byte-lane alignment for stores, extraction with sign/zero extension for loads, and misalignment detection. It also stalls the pipeline while a transaction is outstanding and registers the write-back result for every instruction, memory or not.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_if.sv | 26 ++
 rtl/lsu_lane_align.sv | 57 +++++
 rtl/lsu.sv | 197 +++++++++++++++++++
 tb/tb_lsu.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: bus widths, one-hot load/store
// encodings coming from the execute stage, and the transaction FSM states.
package lsu_pkg;

  localparam int LSU_XLEN    = 32;
  localparam int LSU_XREG_AW = 5;

  localparam logic [4:0] NO_LOAD = 5'b00000;
  localparam logic [4:0] LOAD_B  = 5'b00001;
  localparam logic [4:0] LOAD_H  = 5'b00010;
  localparam logic [4:0] LOAD_W  = 5'b00100;
  localparam logic [4:0] LOAD_BU = 5'b01000;
  localparam logic [4:0] LOAD_HU = 5'b10000;

  localparam logic [2:0] NO_STORE = 3'b000;
  localparam logic [2:0] STORE_B  = 3'b001;
  localparam logic [2:0] STORE_H  = 3'b010;
  localparam logic [2:0] STORE_W  = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Data-memory req/gnt/rvalid bus; the LSU drives it as master, the memory
// answers as slave.
interface lsu_if #(
  parameter int XLEN = lsu_pkg::LSU_XLEN
);

  logic            dmem_req_out;
  logic            dmem_we_out;
  logic [XLEN-1:0] dmem_addr_out;
  logic [3:0]      dmem_be_out;
  logic [XLEN-1:0] dmem_wdata_out;
  logic            dmem_gnt_in;
  logic            dmem_rvalid_in;
  logic [XLEN-1:0] dmem_rdata_in;

  modport master (
    output dmem_req_out, dmem_we_out, dmem_addr_out, dmem_be_out, dmem_wdata_out,
    input  dmem_gnt_in, dmem_rvalid_in, dmem_rdata_in
  );

  modport slave (
    input  dmem_req_out, dmem_we_out, dmem_addr_out, dmem_be_out, dmem_wdata_out,
    output dmem_gnt_in, dmem_rvalid_in, dmem_rdata_in
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU: store byte enables and lane replication plus
// misalignment on the request side, and load extraction/extension on the response side.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = LSU_XLEN
) (
  input  logic [4:0]      load_flag_i,
  input  logic [2:0]      store_flag_i,
  input  logic [1:0]      req_off_i,
  input  logic [XLEN-1:0] store_data_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            misalign_o,

  input  logic [4:0]      rsp_load_flag_i,
  input  logic [1:0]      rsp_off_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] load_data_o
);

  logic            is_half;
  logic            is_word;
  logic [XLEN-1:0] shifted;

  always_comb begin
    is_half    = (|(load_flag_i & (LOAD_H | LOAD_HU))) | (|(store_flag_i & STORE_H));
    is_word    = (|(load_flag_i & LOAD_W)) | (|(store_flag_i & STORE_W));
    misalign_o = (is_half & req_off_i[0]) | (is_word & (req_off_i != 2'b00));

    // Loads read the whole word, so they keep every lane enabled.
    be_o    = 4'b1111;
    wdata_o = store_data_i;
    if (|(store_flag_i & STORE_B)) begin
      be_o    = 4'b0001 << req_off_i;
      wdata_o = {(XLEN/8){store_data_i[7:0]}};
    end else if (|(store_flag_i & STORE_H)) begin
      be_o    = 4'b0011 << req_off_i;
      wdata_o = {(XLEN/16){store_data_i[15:0]}};
    end
  end

  always_comb begin
    shifted     = rdata_i >> {rsp_off_i, 3'b000};
    load_data_o = rdata_i;
    if (|(rsp_load_flag_i & LOAD_B)) begin
      load_data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
    end else if (|(rsp_load_flag_i & LOAD_BU)) begin
      load_data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
    end else if (|(rsp_load_flag_i & LOAD_H)) begin
      load_data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
    end else if (|(rsp_load_flag_i & LOAD_HU)) begin
      load_data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit behind EX: one outstanding data-memory transaction at a time,
// pipeline stall while busy, and a registered write-back slot for every instruction.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN           = LSU_XLEN,
  parameter int XREG_ADDRWIDTH = LSU_XREG_AW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic [4:0]                load_flag_in,
  input  logic [2:0]                store_flag_in,
  input  logic [XLEN-1:0]           addr_in,
  input  logic [XLEN-1:0]           store_data_in,
  input  logic                      rd_en_in,
  input  logic [XREG_ADDRWIDTH-1:0] rd_addr_in,
  output logic                      stall_out,
  lsu_if.master                     dmem,
  output logic                      wb_valid_out,
  output logic                      wb_en_out,
  output logic [XREG_ADDRWIDTH-1:0] wb_addr_out,
  output logic [XLEN-1:0]           wb_data_out,
  output logic                      misalign_out
);

  lsu_state_e state_q, state_d;

  logic                      req_q, req_d;
  logic                      we_q, we_d;
  logic [XLEN-1:0]           addr_q, addr_d;
  logic [3:0]                be_q, be_d;
  logic [XLEN-1:0]           wdata_q, wdata_d;
  logic [4:0]                cap_load_q, cap_load_d;
  logic [1:0]                cap_off_q, cap_off_d;
  logic                      cap_rd_en_q, cap_rd_en_d;
  logic [XREG_ADDRWIDTH-1:0] cap_rd_addr_q, cap_rd_addr_d;
  logic                      wb_valid_q, wb_valid_d;
  logic                      wb_en_q, wb_en_d;
  logic [XREG_ADDRWIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [XLEN-1:0]           wb_data_q, wb_data_d;
  logic                      misalign_q, misalign_d;

  logic            is_load;
  logic [2:0]      store_flag_eff;
  logic            is_mem;
  logic            load_done;
  logic [3:0]      lane_be;
  logic [XLEN-1:0] lane_wdata;
  logic            lane_misalign;
  logic [XLEN-1:0] load_data;

  // A load kind takes precedence, so a malformed pair never becomes a write.
  assign is_load        = |load_flag_in;
  assign store_flag_eff = is_load ? NO_STORE : store_flag_in;
  assign is_mem         = is_load | (|store_flag_eff);

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .load_flag_i     (load_flag_in),
    .store_flag_i    (store_flag_eff),
    .req_off_i       (addr_in[1:0]),
    .store_data_i    (store_data_in),
    .be_o            (lane_be),
    .wdata_o         (lane_wdata),
    .misalign_o      (lane_misalign),
    .rsp_load_flag_i (cap_load_q),
    .rsp_off_i       (cap_off_q),
    .rdata_i         (dmem.dmem_rdata_in),
    .load_data_o     (load_data)
  );

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    cap_load_d    = cap_load_q;
    cap_off_d     = cap_off_q;
    cap_rd_en_d   = cap_rd_en_q;
    cap_rd_addr_d = cap_rd_addr_q;
    wb_valid_d    = 1'b0;
    wb_en_d       = 1'b0;
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;
    misalign_d    = 1'b0;
    load_done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_en_d    = rd_en_in;
            wb_addr_d  = rd_addr_in;
            wb_data_d  = addr_in;
          end else if (lane_misalign) begin
            // Dropped access retires without a write; the faulting address rides along.
            misalign_d = 1'b1;
            wb_valid_d = 1'b1;
            wb_addr_d  = rd_addr_in;
            wb_data_d  = addr_in;
          end else begin
            state_d       = REQ;
            req_d         = 1'b1;
            we_d          = ~is_load;
            addr_d        = {addr_in[XLEN-1:2], 2'b00};
            be_d          = lane_be;
            wdata_d       = is_load ? '0 : lane_wdata;
            cap_load_d    = load_flag_in;
            cap_off_d     = addr_in[1:0];
            cap_rd_en_d   = rd_en_in;
            cap_rd_addr_d = rd_addr_in;
          end
        end
      end
      REQ: begin
        if (dmem.dmem_gnt_in) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_addr_d  = cap_rd_addr_q;
          end else if (dmem.dmem_rvalid_in) begin
            load_done = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem.dmem_rvalid_in) begin
          load_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_done) begin
      state_d    = IDLE;
      wb_valid_d = 1'b1;
      wb_en_d    = cap_rd_en_q;
      wb_addr_d  = cap_rd_addr_q;
      wb_data_d  = load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      be_q          <= '0;
      wdata_q       <= '0;
      cap_load_q    <= '0;
      cap_off_q     <= '0;
      cap_rd_en_q   <= 1'b0;
      cap_rd_addr_q <= '0;
      wb_valid_q    <= 1'b0;
      wb_en_q       <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      cap_load_q    <= cap_load_d;
      cap_off_q     <= cap_off_d;
      cap_rd_en_q   <= cap_rd_en_d;
      cap_rd_addr_q <= cap_rd_addr_d;
      wb_valid_q    <= wb_valid_d;
      wb_en_q       <= wb_en_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      misalign_q    <= misalign_d;
    end
  end

  assign stall_out           = (state_q != IDLE);
  assign dmem.dmem_req_out   = req_q;
  assign dmem.dmem_we_out    = we_q;
  assign dmem.dmem_addr_out  = addr_q;
  assign dmem.dmem_be_out    = be_q;
  assign dmem.dmem_wdata_out = wdata_q;
  assign wb_valid_out        = wb_valid_q;
  assign wb_en_out           = wb_en_q;
  assign wb_addr_out         = wb_addr_q;
  assign wb_data_out         = wb_data_q;
  assign misalign_out        = misalign_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: scenario tasks drive EX and memory, queue the expected
// write-back and compare it when the retire pulse appears.
module tb_lsu;
  import lsu_pkg::*;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        chk_data;
  } wb_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [4:0]  load_flag_in;
  logic [2:0]  store_flag_in;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic        rd_en_in;
  logic [4:0]  rd_addr_in;
  logic        stall_out;
  logic        wb_valid_out;
  logic        wb_en_out;
  logic [4:0]  wb_addr_out;
  logic [31:0] wb_data_out;
  logic        misalign_out;

  lsu_if #(.XLEN(32)) dmem ();

  lsu #(.XLEN(32), .XREG_ADDRWIDTH(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .load_flag_in  (load_flag_in),
    .store_flag_in (store_flag_in),
    .addr_in       (addr_in),
    .store_data_in (store_data_in),
    .rd_en_in      (rd_en_in),
    .rd_addr_in    (rd_addr_in),
    .stall_out     (stall_out),
    .dmem          (dmem),
    .wb_valid_out  (wb_valid_out),
    .wb_en_out     (wb_en_out),
    .wb_addr_out   (wb_addr_out),
    .wb_data_out   (wb_data_out),
    .misalign_out  (misalign_out)
  );

  always #5 clk = ~clk;

  int checks     = 0;
  int failures   = 0;
  int wb_pulses  = 0;
  int exp_pulses = 0;
  wb_exp_t sb[$];

  always @(negedge clk) begin
    if (wb_valid_out === 1'b1) wb_pulses++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in             = 1'b0;
    load_flag_in         = NO_LOAD;
    store_flag_in        = NO_STORE;
    addr_in              = '0;
    store_data_in        = '0;
    rd_en_in             = 1'b0;
    rd_addr_in           = '0;
    dmem.dmem_gnt_in     = 1'b0;
    dmem.dmem_rvalid_in  = 1'b0;
    dmem.dmem_rdata_in   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) step();
    checks++;
    if ({dmem.dmem_req_out, dmem.dmem_we_out, dmem.dmem_be_out, dmem.dmem_addr_out, dmem.dmem_wdata_out} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_dmem: req=%b we=%b be=%b addr=%h wdata=%h, all required 0",
               dmem.dmem_req_out, dmem.dmem_we_out, dmem.dmem_be_out, dmem.dmem_addr_out, dmem.dmem_wdata_out);
    end
    checks++;
    if ({wb_valid_out, wb_en_out, wb_addr_out, wb_data_out, misalign_out, stall_out} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_wb: valid=%b en=%b addr=%0d data=%h mis=%b stall=%b, all required 0",
               wb_valid_out, wb_en_out, wb_addr_out, wb_data_out, misalign_out, stall_out);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_alu();
    wb_exp_t e;
    valid_in = 1'b1; addr_in = 32'h0000_1234; rd_en_in = 1'b1; rd_addr_in = 5'd5;
    sb.push_back('{1'b1, 5'd5, 32'h0000_1234, 1'b1}); exp_pulses++;
    step();
    idle_inputs();
    checks++;
    if (wb_valid_out !== 1'b1 || dmem.dmem_req_out !== 1'b0 || stall_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL alu_retire: valid=%b req=%b stall=%b, required 1/0/0", wb_valid_out, dmem.dmem_req_out, stall_out);
    end else begin
      e = sb.pop_front();
      if ({wb_en_out, wb_addr_out, wb_data_out} !== {e.en, e.addr, e.data}) begin
        failures++;
        $display("[TB] FAIL alu_wb: en=%b addr=%0d data=%h, required en=%b addr=%0d data=%h",
                 wb_en_out, wb_addr_out, wb_data_out, e.en, e.addr, e.data);
      end
    end
    step();
    checks++;
    if (wb_valid_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL alu_pulse: wb_valid=%b one cycle later, required 0", wb_valid_out);
    end
  endtask

  task automatic test_back_to_back();
    wb_exp_t e;
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1; addr_in = 32'hA000_0000 | 32'(i * 257); rd_en_in = i[0]; rd_addr_in = 5'(i + 10);
      sb.push_back('{i[0], 5'(i + 10), 32'hA000_0000 | 32'(i * 257), 1'b1}); exp_pulses++;
      step();
      checks++;
      if (wb_valid_out !== 1'b1 || stall_out !== 1'b0) begin
        failures++;
        $display("[TB] FAIL b2b_retire[%0d]: valid=%b stall=%b, required 1/0", i, wb_valid_out, stall_out);
      end else begin
        e = sb.pop_front();
        if ({wb_en_out, wb_addr_out, wb_data_out} !== {e.en, e.addr, e.data}) begin
          failures++;
          $display("[TB] FAIL b2b_wb[%0d]: en=%b addr=%0d data=%h, required en=%b addr=%0d data=%h",
                   i, wb_en_out, wb_addr_out, wb_data_out, e.en, e.addr, e.data);
        end
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_loads();
    logic [4:0]  kf [6] = '{LOAD_B, LOAD_BU, LOAD_H, LOAD_W, LOAD_B, LOAD_HU};
    logic [31:0] ka [6] = '{32'h103, 32'h103, 32'h102, 32'h104, 32'h101, 32'h000};
    logic [31:0] kd [6] = '{32'h80FF_0000, 32'h80FF_0000, 32'h8001_5678, 32'hCAFE_F00D, 32'h1234_7F00, 32'h1234_F00D};
    logic [31:0] kx [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'hCAFE_F00D, 32'h0000_007F, 32'h0000_F00D};
    int          kw [6] = '{0, 0, 0, 1, 2, 0};
    wb_exp_t     e;
    for (int i = 0; i < 6; i++) begin
      valid_in = 1'b1; load_flag_in = kf[i]; addr_in = ka[i]; rd_en_in = 1'b1; rd_addr_in = 5'(i + 1);
      sb.push_back('{1'b1, 5'(i + 1), kx[i], 1'b1}); exp_pulses++;
      step();
      idle_inputs();
      checks++;
      if (dmem.dmem_req_out !== 1'b1 || dmem.dmem_we_out !== 1'b0 || dmem.dmem_addr_out !== (ka[i] & ~32'h3) || stall_out !== 1'b1) begin
        failures++;
        $display("[TB] FAIL load_req[%0d]: req=%b we=%b addr=%h stall=%b, required 1/0/%h/1",
                 i, dmem.dmem_req_out, dmem.dmem_we_out, dmem.dmem_addr_out, stall_out, ka[i] & ~32'h3);
      end
      dmem.dmem_gnt_in = 1'b1;
      step();
      dmem.dmem_gnt_in = 1'b0;
      checks++;
      if (dmem.dmem_req_out !== 1'b0 || stall_out !== 1'b1 || wb_valid_out !== 1'b0) begin
        failures++;
        $display("[TB] FAIL load_wait[%0d]: req=%b stall=%b wb_valid=%b, required 0/1/0",
                 i, dmem.dmem_req_out, stall_out, wb_valid_out);
      end
      for (int k = 0; k < kw[i]; k++) begin
        step();
        checks++;
        if (stall_out !== 1'b1 || wb_valid_out !== 1'b0) begin
          failures++;
          $display("[TB] FAIL load_hold[%0d.%0d]: stall=%b wb_valid=%b, required 1/0", i, k, stall_out, wb_valid_out);
        end
      end
      dmem.dmem_rvalid_in = 1'b1; dmem.dmem_rdata_in = kd[i];
      step();
      dmem.dmem_rvalid_in = 1'b0; dmem.dmem_rdata_in = '0;
      checks++;
      if (wb_valid_out !== 1'b1 || stall_out !== 1'b0) begin
        failures++;
        $display("[TB] FAIL load_retire[%0d]: valid=%b stall=%b, required 1/0", i, wb_valid_out, stall_out);
      end else begin
        e = sb.pop_front();
        if ({wb_en_out, wb_addr_out, wb_data_out} !== {e.en, e.addr, e.data}) begin
          failures++;
          $display("[TB] FAIL load_wb[%0d]: en=%b addr=%0d data=%h, required en=%b addr=%0d data=%h",
                   i, wb_en_out, wb_addr_out, wb_data_out, e.en, e.addr, e.data);
        end
      end
    end
    step();
  endtask

  task automatic test_stores();
    logic [2:0]  sf [4] = '{STORE_H, STORE_B, STORE_W, STORE_B};
    logic [31:0] sa [4] = '{32'h202, 32'h001, 32'h008, 32'h003};
    logic [31:0] sd [4] = '{32'hDEAD_BEEF, 32'h1234_56A7, 32'h89AB_CDEF, 32'h0000_0055};
    logic [3:0]  sbe [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
    logic [31:0] swd [4] = '{32'hBEEF_BEEF, 32'hA7A7_A7A7, 32'h89AB_CDEF, 32'h5555_5555};
    int          sg [4] = '{2, 0, 1, 0};
    wb_exp_t     e;
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1; store_flag_in = sf[i]; addr_in = sa[i]; store_data_in = sd[i];
      rd_en_in = 1'b1; rd_addr_in = 5'(i + 20);
      sb.push_back('{1'b0, 5'(i + 20), 32'h0, 1'b0}); exp_pulses++;
      step();
      idle_inputs();
      for (int k = 0; k <= sg[i]; k++) begin
        checks++;
        if (dmem.dmem_req_out !== 1'b1 || dmem.dmem_we_out !== 1'b1 || dmem.dmem_be_out !== sbe[i] ||
            dmem.dmem_wdata_out !== swd[i] || dmem.dmem_addr_out !== (sa[i] & ~32'h3) || stall_out !== 1'b1) begin
          failures++;
          $display("[TB] FAIL store_req[%0d.%0d]: req=%b we=%b be=%b wdata=%h addr=%h stall=%b, required 1/1/%b/%h/%h/1",
                   i, k, dmem.dmem_req_out, dmem.dmem_we_out, dmem.dmem_be_out, dmem.dmem_wdata_out,
                   dmem.dmem_addr_out, stall_out, sbe[i], swd[i], sa[i] & ~32'h3);
        end
        if (k == sg[i]) dmem.dmem_gnt_in = 1'b1;
        step();
      end
      dmem.dmem_gnt_in = 1'b0;
      checks++;
      if (wb_valid_out !== 1'b1 || dmem.dmem_req_out !== 1'b0 || stall_out !== 1'b0) begin
        failures++;
        $display("[TB] FAIL store_retire[%0d]: valid=%b req=%b stall=%b, required 1/0/0",
                 i, wb_valid_out, dmem.dmem_req_out, stall_out);
      end else begin
        e = sb.pop_front();
        if ({wb_en_out, wb_addr_out} !== {e.en, e.addr}) begin
          failures++;
          $display("[TB] FAIL store_wb[%0d]: en=%b addr=%0d, required en=%b addr=%0d",
                   i, wb_en_out, wb_addr_out, e.en, e.addr);
        end
      end
    end
    step();
  endtask

  task automatic test_misalign();
    logic [4:0]  mf [6] = '{LOAD_W, LOAD_H, LOAD_HU, NO_LOAD, NO_LOAD, LOAD_W};
    logic [2:0]  ms [6] = '{NO_STORE, NO_STORE, NO_STORE, STORE_W, STORE_H, NO_STORE};
    logic [31:0] ma [6] = '{32'h301, 32'h001, 32'h003, 32'h002, 32'h005, 32'h302};
    wb_exp_t     e;
    for (int i = 0; i < 6; i++) begin
      valid_in = 1'b1; load_flag_in = mf[i]; store_flag_in = ms[i]; addr_in = ma[i];
      store_data_in = 32'h1111_2222; rd_en_in = 1'b1; rd_addr_in = 5'(i + 3);
      sb.push_back('{1'b0, 5'(i + 3), 32'h0, 1'b0}); exp_pulses++;
      step();
      checks++;
      if (misalign_out !== 1'b1 || wb_valid_out !== 1'b1 || dmem.dmem_req_out !== 1'b0 || stall_out !== 1'b0) begin
        failures++;
        $display("[TB] FAIL misalign[%0d]: mis=%b valid=%b req=%b stall=%b, required 1/1/0/0",
                 i, misalign_out, wb_valid_out, dmem.dmem_req_out, stall_out);
      end else begin
        e = sb.pop_front();
        if ({wb_en_out, wb_addr_out} !== {e.en, e.addr}) begin
          failures++;
          $display("[TB] FAIL misalign_wb[%0d]: en=%b addr=%0d, required en=%b addr=%0d",
                   i, wb_en_out, wb_addr_out, e.en, e.addr);
        end
      end
    end
    idle_inputs();
    step();
    checks++;
    if (misalign_out !== 1'b0 || wb_valid_out !== 1'b0 || stall_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL misalign_end: mis=%b valid=%b stall=%b, required 0/0/0", misalign_out, wb_valid_out, stall_out);
    end
  endtask

  task automatic test_same_cycle();
    wb_exp_t e;
    valid_in = 1'b1; load_flag_in = LOAD_HU; addr_in = 32'h002; rd_en_in = 1'b1; rd_addr_in = 5'd12;
    sb.push_back('{1'b1, 5'd12, 32'h0000_A5A5, 1'b1}); exp_pulses++;
    step();
    idle_inputs();
    checks++;
    if (dmem.dmem_req_out !== 1'b1 || stall_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL same_req: req=%b stall=%b, required 1/1", dmem.dmem_req_out, stall_out);
    end
    dmem.dmem_gnt_in = 1'b1; dmem.dmem_rvalid_in = 1'b1; dmem.dmem_rdata_in = 32'hA5A5_1234;
    step();
    idle_inputs();
    checks++;
    if (wb_valid_out !== 1'b1 || stall_out !== 1'b0 || dmem.dmem_req_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL same_retire: valid=%b stall=%b req=%b, required 1/0/0", wb_valid_out, stall_out, dmem.dmem_req_out);
    end else begin
      e = sb.pop_front();
      if ({wb_en_out, wb_addr_out, wb_data_out} !== {e.en, e.addr, e.data}) begin
        failures++;
        $display("[TB] FAIL same_wb: en=%b addr=%0d data=%h, required en=%b addr=%0d data=%h",
                 wb_en_out, wb_addr_out, wb_data_out, e.en, e.addr, e.data);
      end
    end
    step();
  endtask

  task automatic test_stray_rvalid();
    dmem.dmem_rvalid_in = 1'b1; dmem.dmem_rdata_in = 32'hFFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (wb_valid_out !== 1'b0 || stall_out !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stray_rvalid[%0d]: valid=%b stall=%b, required 0/0", k, wb_valid_out, stall_out);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    wb_exp_t e;
    int      p;
    valid_in = 1'b1; load_flag_in = LOAD_W; addr_in = 32'h010; rd_en_in = 1'b1; rd_addr_in = 5'd3;
    step();
    idle_inputs();
    p = wb_pulses;
    checks++;
    if (dmem.dmem_req_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstmid_req: req=%b before reset, required 1", dmem.dmem_req_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dmem.dmem_req_out, dmem.dmem_we_out, dmem.dmem_be_out, dmem.dmem_addr_out, dmem.dmem_wdata_out,
         wb_valid_out, wb_en_out, wb_addr_out, wb_data_out, misalign_out, stall_out} !== '0) begin
      failures++;
      $display("[TB] FAIL rstmid_async: req=%b be=%b addr=%h valid=%b stall=%b, all required 0",
               dmem.dmem_req_out, dmem.dmem_be_out, dmem.dmem_addr_out, wb_valid_out, stall_out);
    end
    step();
    rst = 1'b0;
    step();
    step();
    checks++;
    if (wb_pulses !== p) begin
      failures++;
      $display("[TB] FAIL rstmid_nowb: %0d retire pulses after abort, required 0", wb_pulses - p);
    end
    valid_in = 1'b1; load_flag_in = LOAD_W; addr_in = 32'h020; rd_en_in = 1'b1; rd_addr_in = 5'd4;
    sb.push_back('{1'b1, 5'd4, 32'h1122_3344, 1'b1}); exp_pulses++;
    step();
    idle_inputs();
    checks++;
    if (dmem.dmem_req_out !== 1'b1 || dmem.dmem_addr_out !== 32'h020) begin
      failures++;
      $display("[TB] FAIL rstmid_next_req: req=%b addr=%h, required 1/00000020", dmem.dmem_req_out, dmem.dmem_addr_out);
    end
    dmem.dmem_gnt_in = 1'b1;
    step();
    dmem.dmem_gnt_in = 1'b0; dmem.dmem_rvalid_in = 1'b1; dmem.dmem_rdata_in = 32'h1122_3344;
    step();
    idle_inputs();
    checks++;
    if (wb_valid_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstmid_next_retire: valid=%b, required 1", wb_valid_out);
    end else begin
      e = sb.pop_front();
      if ({wb_en_out, wb_addr_out, wb_data_out} !== {e.en, e.addr, e.data}) begin
        failures++;
        $display("[TB] FAIL rstmid_next_wb: en=%b addr=%0d data=%h, required en=%b addr=%0d data=%h",
                 wb_en_out, wb_addr_out, wb_data_out, e.en, e.addr, e.data);
      end
    end
    step();
  endtask

  task automatic test_pulse_count();
    step();
    checks++;
    if (wb_pulses !== exp_pulses) begin
      failures++;
      $display("[TB] FAIL pulse_count: %0d retire pulses, required %0d", wb_pulses, exp_pulses);
    end
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
  endtask

  initial begin
    $display("[TB] lsu bench start");
    test_reset();
    test_alu();
    test_back_to_back();
    test_loads();
    test_stores();
    test_misalign();
    test_same_cycle();
    test_stray_rvalid();
    test_reset_mid();
    test_pulse_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
